// File: rtl/dp_encoder.sv
// dp_encoder: ARM data-processing instruction encoder with iterative immediate rotation search (optional DP_ENCODER_ALT_IMM_EN retries with ~imm / -imm)
module dp_encoder #(
  parameter int CHECKS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_opcode,
  input  logic        in_s,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic        in_imm_mode,
  input  logic [31:0] in_imm,
  input  logic [3:0]  in_rm,
  input  logic [1:0]  in_shift_type,
  input  logic        in_shift_reg,
  input  logic [3:0]  in_rs,
  input  logic [4:0]  in_shift_amt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);
  localparam int C = CHECKS_PER_CYCLE;
  localparam int G = 16 / C;
`ifdef DP_ENCODER_ALT_IMM_EN
  typedef enum logic [1:0] {IDLE, SEARCH, OUT, ALT} state_t;
  function automatic logic has_alt(input logic [3:0] op);
    return op inside {4'h0, 4'hE, 4'hD, 4'hF, 4'h4, 4'h2, 4'hA, 4'hB};
  endfunction
  function automatic logic [3:0] swap_op(input logic [3:0] op);
    return (op[3:2] == 2'b11 && op[0]) ? op ^ 4'b0010 :
           (op == 4'h0 || op == 4'hE) ? op ^ 4'b1110 :
           (op == 4'h4 || op == 4'h2) ? op ^ 4'b0110 : op ^ 4'b0001;
  endfunction
  function automatic logic [31:0] alt_imm(input logic [3:0] op, input logic [31:0] imm);
    return (op inside {4'h0, 4'hE, 4'hD, 4'hF}) ? ~imm : -imm;
  endfunction
`else
  typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;
`endif
  function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] s);
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction
  function automatic logic [31:0] word(input logic [3:0] cond, input logic [3:0] op, input logic s,
                                       input logic [3:0] rn, input logic [3:0] rd, input logic i,
                                       input logic [11:0] op2);
    return {cond, 2'b00, i, op, s | (op[3:2] == 2'b10), (op[3:2] == 2'b11 && op[0]) ? 4'd0 : rn,
            (op[3:2] == 2'b10) ? 4'd0 : rd, op2};
  endfunction
  state_t      state_q, state_d;
  logic [3:0]  cond_q, cond_d, op_q, op_d, rn_q, rn_d, rd_q, rd_d, group_q, group_d;
  logic        s_q, s_d, out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [31:0] imm_q, imm_d, out_instr_q, out_instr_d, rotated;
  logic        hit;
  logic [3:0]  hit_rot, r;
  logic [7:0]  hit_imm8;
  assign in_ready  = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  always_comb begin
    hit      = 1'b0;
    hit_rot  = '0;
    hit_imm8 = '0;
    rotated  = '0;
    r        = '0;
    for (int k = C - 1; k >= 0; k--) begin
      r       = 4'(int'(group_q) * C + k);
      rotated = rol(imm_q, {r, 1'b0});
      if (rotated[31:8] == '0) begin
        hit      = 1'b1;
        hit_rot  = r;
        hit_imm8 = rotated[7:0];
      end
    end
  end
  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    op_d        = op_q;
    s_d         = s_q;
    rn_d        = rn_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    group_d     = group_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE: if (in_valid) begin
        cond_d  = in_cond;
        op_d    = in_opcode;
        s_d     = in_s;
        rn_d    = in_rn;
        rd_d    = in_rd;
        imm_d   = in_imm;
        group_d = '0;
        state_d = in_imm_mode ? SEARCH : OUT;
        if (!in_imm_mode) begin
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          out_instr_d = word(in_cond, in_opcode, in_s, in_rn, in_rd, 1'b0,
                             in_shift_reg ? {in_rs, 1'b0, in_shift_type, 1'b1, in_rm}
                                          : {in_shift_amt, in_shift_type, 1'b0, in_rm});
        end
      end
      OUT: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
      default: if (hit) begin
        state_d     = OUT;
        out_valid_d = 1'b1;
        out_err_d   = 1'b0;
        out_instr_d = word(cond_q, op_q, s_q, rn_q, rd_q, 1'b1, {hit_rot, hit_imm8});
      end else if (group_q == 4'(G - 1)) begin
        state_d     = OUT;
        out_valid_d = 1'b1;
        out_err_d   = 1'b1;
        out_instr_d = '0;
`ifdef DP_ENCODER_ALT_IMM_EN
        if (state_q == SEARCH && has_alt(op_q)) begin
          state_d     = ALT;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          group_d     = '0;
          imm_d       = alt_imm(op_q, imm_q);
          op_d        = swap_op(op_q);
        end
`endif
      end else begin
        group_d = group_q + 4'd1;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cond_q      <= '0;
      op_q        <= '0;
      s_q         <= 1'b0;
      rn_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      group_q     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cond_q      <= cond_d;
      op_q        <= op_d;
      s_q         <= s_d;
      rn_q        <= rn_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      group_q     <= group_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
    end
  end
endmodule

// File: tb/tb_dp_encoder.sv
// tb_dp_encoder: randomized self-checking bench for dp_encoder against a brute-force encoding model
module tb_dp_encoder;
  localparam int C = 1;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_s = 1'b0, in_imm_mode = 1'b0, in_shift_reg = 1'b0;
  logic [3:0]  in_cond = '0, in_opcode = '0, in_rn = '0, in_rd = '0, in_rm = '0, in_rs = '0;
  logic [31:0] in_imm = '0, out_instr;
  logic [1:0]  in_shift_type = '0;
  logic [4:0]  in_shift_amt = '0;
  logic        out_valid, out_ready = 1'b0, out_err;
  int          n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  dp_encoder #(.CHECKS_PER_CYCLE(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond),
    .in_opcode(in_opcode), .in_s(in_s), .in_rn(in_rn), .in_rd(in_rd), .in_imm_mode(in_imm_mode),
    .in_imm(in_imm), .in_rm(in_rm), .in_shift_type(in_shift_type), .in_shift_reg(in_shift_reg),
    .in_rs(in_rs), .in_shift_amt(in_shift_amt), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err)
  );
  typedef struct {
    logic [3:0] cond, op, rn, rd, rm, rs;
    logic s, imm_mode, sr;
    logic [31:0] imm;
    logic [1:0] st;
    logic [4:0] amt;
  } req_t;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int find_rot(input logic [31:0] v, output logic [7:0] imm8);
    for (int rr = 0; rr < 16; rr++) begin
      for (int b = 0; b < 256; b++) begin
        logic [63:0] d;
        d = {24'h0, 8'(b), 24'h0, 8'(b)};
        if (32'(d >> (2 * rr)) == v) begin
          imm8 = 8'(b);
          return rr;
        end
      end
    end
    imm8 = '0;
    return -1;
  endfunction
  function automatic logic [31:0] build(input req_t q, input logic [3:0] op, input logic i, input logic [11:0] op2);
    logic cmp, mv;
    cmp = op inside {4'h8, 4'h9, 4'hA, 4'hB};
    mv  = op inside {4'hD, 4'hF};
    return (32'(q.cond) << 28) | (32'(i) << 25) | (32'(op) << 21) | (32'(q.s | cmp) << 20) |
           (mv ? 32'h0 : 32'(q.rn) << 16) | (cmp ? 32'h0 : 32'(q.rd) << 12) | 32'(op2);
  endfunction
  function automatic void model(input req_t q, output logic [31:0] w, output logic err, output int lat);
    int rr;
    logic [7:0] i8;
    err = 1'b0;
    if (!q.imm_mode) begin
      w = build(q, q.op, 1'b0, q.sr ? {q.rs, 1'b0, q.st, 1'b1, q.rm} : {q.amt, q.st, 1'b0, q.rm});
      lat = 1;
      return;
    end
    rr = find_rot(q.imm, i8);
    if (rr >= 0) begin
      w = build(q, q.op, 1'b1, {4'(rr), i8});
      lat = 2 + rr / C;
      return;
    end
    lat = 1 + 16 / C;
`ifdef DP_ENCODER_ALT_IMM_EN
    if (q.op inside {4'h0, 4'hE, 4'hD, 4'hF, 4'h4, 4'h2, 4'hA, 4'hB}) begin
      logic [3:0] sw;
      logic [31:0] av;
      case (q.op)
        4'hD: sw = 4'hF;  4'hF: sw = 4'hD;
        4'h0: sw = 4'hE;  4'hE: sw = 4'h0;
        4'h4: sw = 4'h2;  4'h2: sw = 4'h4;
        4'hA: sw = 4'hB;  default: sw = 4'hA;
      endcase
      av = (q.op inside {4'h0, 4'hE, 4'hD, 4'hF}) ? ~q.imm : 32'(0) - q.imm;
      rr = find_rot(av, i8);
      if (rr >= 0) begin
        w = build(q, sw, 1'b1, {4'(rr), i8});
        lat = 2 + 16 / C + rr / C;
        return;
      end
      lat = 1 + 32 / C;
    end
`endif
    w = '0;
    err = 1'b1;
  endfunction
  function automatic req_t mk(input logic [3:0] cond, op, input logic s, input logic [3:0] rn, rd,
                              input logic imm_mode, input logic [31:0] imm);
    req_t q;
    q.cond = cond; q.op = op; q.s = s; q.rn = rn; q.rd = rd; q.imm_mode = imm_mode; q.imm = imm;
    q.rm = '0; q.rs = '0; q.sr = 1'b0; q.st = '0; q.amt = '0;
    return q;
  endfunction
  function automatic req_t rnd();
    req_t q;
    logic [63:0] d;
    logic [31:0] e;
    q = mk(4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), $urandom);
    q.rm = 4'($urandom); q.rs = 4'($urandom); q.sr = 1'($urandom); q.st = 2'($urandom);
    q.amt = 5'($urandom);
    d = {24'h0, 8'($urandom), 24'h0, 8'($urandom)};
    d[63:32] = d[31:0];
    e = 32'(d >> (2 * $urandom_range(0, 15)));
    case ($urandom_range(0, 3))
      0: q.imm = e;
      1: q.imm = ~e;
      2: q.imm = 32'(0) - e;
      default: ;
    endcase
    return q;
  endfunction
  task automatic run(input req_t q, input int hold, input string tag);
    logic [31:0] w;
    logic e;
    int lat, l;
    model(q, w, e, lat);
    @(negedge clk);
    chk({tag, " in_ready_idle"}, in_ready, 1);
    in_valid = 1; in_cond = q.cond; in_opcode = q.op; in_s = q.s; in_rn = q.rn; in_rd = q.rd;
    in_imm_mode = q.imm_mode; in_imm = q.imm; in_rm = q.rm; in_shift_type = q.st;
    in_shift_reg = q.sr; in_rs = q.rs; in_shift_amt = q.amt;
    @(negedge clk);
    in_valid = 0;
    l = 1;
    while (!out_valid && l < 200) begin
      @(negedge clk);
      l++;
    end
    chk({tag, " latency"}, 32'(l), 32'(lat));
    chk({tag, " instr"}, out_instr, w);
    chk({tag, " err"}, out_err, e);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1;
      in_imm_mode = 0;
      in_opcode = ~q.op;
      @(negedge clk);
      chk({tag, " hold_instr"}, out_instr, w);
      chk({tag, " hold_valid"}, out_valid, 1);
      chk({tag, " hold_in_ready"}, in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, " post_valid"}, out_valid, 0);
    chk({tag, " post_in_ready"}, in_ready, 1);
  endtask
  initial begin
    req_t q;
    int stale;
    #2;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_instr", out_instr, 0);
    chk("reset out_err", out_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    run(mk(4'hE, 4'h4, 0, 4'd2, 4'd1, 1, 32'h000000FF), 0, "add_ff");
    chk("add_ff literal", out_instr, 32'hE28210FF);
    run(mk(4'hE, 4'hD, 0, 4'd7, 4'd0, 1, 32'hFF000000), 0, "mov_rot4");
    chk("mov_rot4 literal", out_instr, 32'hE3A004FF);
    q = mk(4'hE, 4'h2, 1, 4'd4, 4'd3, 0, 32'h0);
    q.rm = 4'd5; q.amt = 5'd2;
    run(q, 0, "sub_reg");
    chk("sub_reg literal", out_instr, 32'hE0543105);
    run(mk(4'hE, 4'hD, 0, 4'd0, 4'd0, 1, 32'h00000101), 0, "mov_101");
    run(mk(4'hE, 4'hD, 0, 4'd0, 4'd0, 1, 32'hFFFFFF00), 0, "mov_ffffff00");
    run(mk(4'h1, 4'hA, 0, 4'd3, 4'd9, 1, 32'h0), 0, "cmp_zero");
    run(mk(4'h0, 4'hC, 1, 4'd1, 4'd2, 1, 32'hC000003F), 0, "orr_wrap");
    run(mk(4'h0, 4'h4, 0, 4'd1, 4'd2, 1, 32'h3FC00000), 5, "backpressure");
    for (int i = 0; i < 40; i++) run(rnd(), $urandom_range(0, 2), $sformatf("rnd%0d", i));
    @(negedge clk);
    in_valid = 1; in_imm_mode = 1; in_imm = 32'h00000101; in_opcode = 4'hD;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort out_instr", out_instr, 0);
    chk("abort in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || !in_ready) stale++;
    end
    chk("abort no_stale", 32'(stale), 0);
    run(mk(4'hE, 4'h4, 0, 4'd2, 4'd1, 1, 32'h000000FF), 0, "after_abort");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
